scpu_sram_io_slave: RTL

- On-chip responder for the FPGA-side serial SRAM loader.
- Receives a {addr, data} word serially on SI after a one-cycle LOAD pulse and returns the previous readback word on SO in the same exchange.
- On a BGN rising edge it executes the command selected by MOD: SRAM write, SRAM read, or hand-off to the CPU.
- Sits between the chip pads and the SCPU instruction SRAM and run control.

---
 rtl/scpu_io_pkg.sv | 28 ++
 rtl/scpu_sram_io_slave_if.sv | 31 +++
 rtl/scpu_io_shift_reg.sv | 35 +++
 rtl/scpu_sram_io_slave.sv | 97 +++++++++
 4 files changed

// File: rtl/scpu_io_pkg.sv
// Shared types and constants for the SCPU serial SRAM loader responder.
package scpu_io_pkg;

    localparam int MEM_DATA_W_DEF = 8;
    localparam int MEM_ADDR_W_DEF = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        RWAIT = 3'd4,
        RUN   = 3'd5
    } state_t;

    localparam logic [1:0] MODE_NOP = 2'b00;
    localparam logic [1:0] MODE_WR  = 2'b01;
    localparam logic [1:0] MODE_RD  = 2'b10;
    localparam logic [1:0] MODE_RUN = 2'b11;

    // Serial word is {addr, data}, so its length follows the SRAM geometry.
    function automatic int reg_bits_width(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    localparam int REG_BITS_WIDTH_DEF = reg_bits_width(MEM_ADDR_W_DEF, MEM_DATA_W_DEF);

endpackage

// File: rtl/scpu_sram_io_slave_if.sv
// Pad-side control, SRAM and CPU hand-off signals of the loader responder.
interface scpu_sram_io_slave_if #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9
);
    logic                         ctrl_load_i;
    logic                         ctrl_si_i;
    logic                         ctrl_bgn_i;
    logic [1:0]                   ctrl_mod_i;
    logic                         ctrl_so_o;
    logic                         ctrl_rdy_o;
    logic [MEMORY_ADDR_WIDTH-1:0] sram_addr_o;
    logic [MEMORY_DATA_WIDTH-1:0] sram_wdata_o;
    logic                         sram_we_o;
    logic                         sram_re_o;
    logic [MEMORY_DATA_WIDTH-1:0] sram_rdata_i;
    logic                         cpu_run_o;
    logic                         cpu_done_i;

    modport slave (
        input  ctrl_load_i, ctrl_si_i, ctrl_bgn_i, ctrl_mod_i, sram_rdata_i, cpu_done_i,
        output ctrl_so_o, ctrl_rdy_o, sram_addr_o, sram_wdata_o, sram_we_o, sram_re_o,
               cpu_run_o
    );

    modport master (
        output ctrl_load_i, ctrl_si_i, ctrl_bgn_i, ctrl_mod_i, sram_rdata_i, cpu_done_i,
        input  ctrl_so_o, ctrl_rdy_o, sram_addr_o, sram_wdata_o, sram_we_o, sram_re_o,
               cpu_run_o
    );
endinterface

// File: rtl/scpu_io_shift_reg.sv
// Serial exchange shifter: parallel load, LSB-first shift, bit counter and last-shift flag.
module scpu_io_shift_reg #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             si,
    output logic [WIDTH-1:0] word,
    output logic             done
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;

    // A nonzero counter means an exchange is in flight; load always restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (load) begin
            shift_reg <= load_word;
            bit_cnt   <= CNT_W'(WIDTH);
        end else if (bit_cnt != '0) begin
            shift_reg <= {si, shift_reg[WIDTH-1:1]};
            bit_cnt   <= bit_cnt - CNT_W'(1);
        end
    end

    assign word = shift_reg;
    assign done = (bit_cnt == CNT_W'(1));

endmodule

// File: rtl/scpu_sram_io_slave.sv
// On-chip responder for the serial SRAM loader: serial exchange, SRAM write/read and CPU hand-off.
module scpu_sram_io_slave
    import scpu_io_pkg::*;
#(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9,
    parameter int RD_LATENCY        = 1
) (
    input  logic                 csi_clk,
    input  logic                 rsi_reset_n,
    scpu_sram_io_slave_if.slave  bus
);
    localparam int REG_BITS_WIDTH = reg_bits_width(MEMORY_ADDR_WIDTH, MEMORY_DATA_WIDTH);
    localparam int RD_CNT_W       = $clog2(RD_LATENCY + 1);

    state_t                    state;
    logic [REG_BITS_WIDTH-1:0] rb_word;
    logic [REG_BITS_WIDTH-1:0] shift_word;
    logic [RD_CNT_W-1:0]       rd_cnt;
    logic                      bgn_d;
    logic                      bgn_edge;
    logic                      load_ok;
    logic                      sh_done;

    // Commands own the shift register while they run, so LOAD is only honoured when idle or shifting.
    assign load_ok  = bus.ctrl_load_i && (state == IDLE || state == SHIFT);
    assign bgn_edge = bus.ctrl_bgn_i & ~bgn_d;

    scpu_io_shift_reg #(
        .WIDTH(REG_BITS_WIDTH)
    ) u_shift (
        .clk       (csi_clk),
        .rst_n     (rsi_reset_n),
        .load      (load_ok),
        .load_word (rb_word),
        .si        (bus.ctrl_si_i),
        .word      (shift_word),
        .done      (sh_done)
    );

    // bgn_d resets high so a BGN level held through reset release is not an edge.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state   <= IDLE;
            rb_word <= '0;
            rd_cnt  <= '0;
            bgn_d   <= 1'b1;
        end else begin
            bgn_d <= bus.ctrl_bgn_i;
            case (state)
                IDLE: begin
                    if (load_ok) begin
                        state <= SHIFT;
                    end else if (bgn_edge) begin
                        case (bus.ctrl_mod_i)
                            MODE_WR:  state <= WRITE;
                            MODE_RD:  state <= READ;
                            MODE_RUN: state <= RUN;
                            default:  state <= IDLE;
                        endcase
                    end
                end
                SHIFT: begin
                    if (!load_ok && sh_done) state <= IDLE;
                end
                WRITE: begin
                    rb_word <= shift_word;
                    state   <= IDLE;
                end
                READ: begin
                    rd_cnt <= RD_CNT_W'(RD_LATENCY);
                    state  <= RWAIT;
                end
                RWAIT: begin
                    rd_cnt <= rd_cnt - RD_CNT_W'(1);
                    if (rd_cnt == RD_CNT_W'(1)) begin
                        rb_word <= {shift_word[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH], bus.sram_rdata_i};
                        state   <= IDLE;
                    end
                end
                RUN: begin
                    if (bus.cpu_done_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ctrl_so_o    = shift_word[0];
    assign bus.ctrl_rdy_o   = (state == IDLE);
    assign bus.sram_we_o    = (state == WRITE);
    assign bus.sram_re_o    = (state == READ);
    assign bus.cpu_run_o    = (state == RUN);
    assign bus.sram_addr_o  = shift_word[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH];
    assign bus.sram_wdata_o = shift_word[MEMORY_DATA_WIDTH-1:0];

endmodule
